// File: rtl/systolic_feeder.sv
// Systolic array feeder.
// Loads N weight rows into the top array row (one control strobe per accepted
// row), then streams activation vectors into the left array column with a
// diagonal skew (lane i delayed by i cycles), drains the skew line and pulses
// done when the last element leaves lane N-1.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; all outputs quiet
//   LOAD_WT | accepting N weight rows, one control pulse per row
//   STREAM  | accepting activation vectors until act_last
//   DRAIN   | injecting zeros for N-1 cycles until lane N-1 shows the last element
module systolic_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wt_valid,
  input  logic [N*DATA_W-1:0]   wt_row,
  output logic                  wt_ready,
  input  logic                  act_valid,
  input  logic [N*DATA_W-1:0]   act_vec,
  input  logic                  act_last,
  output logic                  act_ready,
  output logic                  control,
  output logic [N*DATA_W-1:0]   wt_path_out,
  output logic [N*DATA_W-1:0]   data_out,
  output logic [N-1:0]          data_vld,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] ROW_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LEN = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_WT = 2'd1,
    STREAM  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   row_cnt, row_cnt_nxt;
  logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
  logic            done_nxt;
  logic            wt_acc;
  logic            act_acc;
  logic            shift_en;

  assign wt_acc   = wt_valid & wt_ready;
  assign act_acc  = act_valid & act_ready;
  assign shift_en = (state == STREAM) || (state == DRAIN);

  // Next-state logic: row counting, end-of-stream detection, drain countdown.
  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    drain_cnt_nxt = drain_cnt;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_WT;
      end
      LOAD_WT: begin
        if (wt_acc) begin
          if (row_cnt == ROW_LAST) begin
            row_cnt_nxt = '0;
            state_nxt   = STREAM;
          end else begin
            row_cnt_nxt = row_cnt + CW'(1);
          end
        end
      end
      STREAM: begin
        if (act_acc && act_last) begin
          if (N == 1) begin
            // No skew to drain: lane 0 already shows the last element.
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LEN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == CW'(1)) begin
          state_nxt     = IDLE;
          done_nxt      = 1'b1;
          drain_cnt_nxt = '0;
        end else begin
          drain_cnt_nxt = drain_cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      drain_cnt   <= '0;
      wt_ready    <= 1'b0;
      act_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      control     <= 1'b0;
      wt_path_out <= '0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      wt_ready  <= (state_nxt == LOAD_WT);
      act_ready <= (state_nxt == STREAM);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
      // Strobe only on a real acceptance so a stall never re-shifts weights.
      control   <= wt_acc;
      if (wt_acc) wt_path_out <= wt_row;
    end
  end

  // Diagonal skew line: lane g is a shift register of depth g+1.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DATA_W-1:0] sd [0:g];
    logic              sv [0:g];

    // Shift while streaming/draining; bubbles enter as zero data, valid low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= g; k++) begin
          sd[k] <= '0;
          sv[k] <= 1'b0;
        end
      end else if (shift_en) begin
        sd[0] <= act_acc ? act_vec[g*DATA_W +: DATA_W] : '0;
        sv[0] <= act_acc;
        for (int k = 1; k <= g; k++) begin
          sd[k] <= sd[k-1];
          sv[k] <= sv[k-1];
        end
      end else begin
        for (int k = 0; k <= g; k++) begin
          sd[k] <= '0;
          sv[k] <= 1'b0;
        end
      end
    end

    assign data_out[g*DATA_W +: DATA_W] = sd[g];
    assign data_vld[g]                  = sv[g];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a job-level model.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          wt_valid = 1'b0;
  logic [LW-1:0] wt_row = '0;
  logic          wt_ready;
  logic          act_valid = 1'b0;
  logic [LW-1:0] act_vec = '0;
  logic          act_last = 1'b0;
  logic          act_ready;
  logic          control;
  logic [LW-1:0] wt_path_out;
  logic [LW-1:0] data_out;
  logic [N-1:0]  data_vld;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  systolic_feeder #(.N(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wt_valid(wt_valid), .wt_row(wt_row), .wt_ready(wt_ready),
    .act_valid(act_valid), .act_vec(act_vec), .act_last(act_last),
    .act_ready(act_ready), .control(control), .wt_path_out(wt_path_out),
    .data_out(data_out), .data_vld(data_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 loading weights, 2 streaming, 3 draining
  int            m_phase;
  int            m_rows;
  int            m_drain;
  logic [LW-1:0] h_vec [N];   // h_vec[i] = vector injected i edges ago
  logic          h_val [N];
  logic          e_control, e_done, e_busy, e_wtr, e_actr;
  logic [LW-1:0] e_wt;
  logic [LW-1:0] e_data;
  logic [N-1:0]  e_vld;
  logic [LW-1:0] inj;
  logic          inj_v;
  logic          shifting;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_rows = 0; m_drain = 0;
      e_control = 0; e_done = 0; e_wt = '0;
      for (int i = 0; i < N; i++) begin h_vec[i] = '0; h_val[i] = 0; end
    end else begin
      shifting  = (m_phase == 2) || (m_phase == 3);
      inj       = '0;
      inj_v     = 0;
      e_control = 0;
      e_done    = 0;
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (wt_valid) begin
             e_control = 1;
             e_wt      = wt_row;
             m_rows++;
             if (m_rows == N) begin m_rows = 0; m_phase = 2; end
           end
        2: if (act_valid) begin
             inj   = act_vec;
             inj_v = 1;
             if (act_last) begin
               m_drain = N - 1;
               m_phase = (N == 1) ? 0 : 3;
               e_done  = (N == 1);
             end
           end
        default: begin
          m_drain--;
          if (m_drain == 0) begin m_phase = 0; e_done = 1; end
        end
      endcase
      if (shifting) begin
        for (int i = N - 1; i > 0; i--) begin h_vec[i] = h_vec[i-1]; h_val[i] = h_val[i-1]; end
        h_vec[0] = inj;
        h_val[0] = inj_v;
      end else begin
        for (int i = 0; i < N; i++) begin h_vec[i] = '0; h_val[i] = 0; end
      end
    end
    e_busy = (m_phase != 0);
    e_wtr  = (m_phase == 1);
    e_actr = (m_phase == 2);
    for (int i = 0; i < N; i++) begin
      e_data[i*W +: W] = h_vec[i][i*W +: W];
      e_vld[i]         = h_val[i];
    end
  end

  // Per-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    chk("m_control",   64'(control),     64'(e_control));
    chk("m_wt_path",   64'(wt_path_out), 64'(e_wt));
    chk("m_wt_ready",  64'(wt_ready),    64'(e_wtr));
    chk("m_act_ready", 64'(act_ready),   64'(e_actr));
    chk("m_data_out",  64'(data_out),    64'(e_data));
    chk("m_data_vld",  64'(data_vld),    64'(e_vld));
    chk("m_busy",      64'(busy),        64'(e_busy));
    chk("m_done",      64'(done),        64'(e_done));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_rows();
    wt_valid = 1'b1;
    for (int r = 0; r < N; r++) begin
      wt_row = LW'($urandom);
      step();
    end
    wt_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outputs",
        {32'd0, wt_path_out},
        64'd0);
    chk("rst_flags",
        64'({control, wt_ready, act_ready, busy, done, data_vld}), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    step();
    rst_n = 1'b1;
  endtask

  logic [LW-1:0] row_v;

  initial begin
    #1 rst_n = 1'b0;
    #20;
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    step();

    // ---- load test and skew test ----
    do_start();
    chk("start_wt_ready", 64'(wt_ready), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    wt_valid = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      row_v  = 32'h01010101 * r;
      wt_row = row_v;
      step();
      chk("load_control", 64'(control), 64'd1);
      chk("load_wt_path", 64'(wt_path_out), 64'(row_v));
    end
    wt_valid = 1'b0;
    chk("load_wt_ready_drop", 64'(wt_ready), 64'd0);
    chk("load_act_ready", 64'(act_ready), 64'd1);
    act_valid = 1'b1; act_vec = 32'h04030201; act_last = 1'b0;
    step();  // E0
    chk("skew_e0_lane0", 64'(data_out[7:0]), 64'd1);
    chk("skew_e0_vld", 64'(data_vld), 64'b0001);
    chk("skew_e0_control", 64'(control), 64'd0);
    act_vec = 32'h08070605; act_last = 1'b1;
    step();  // E1
    chk("skew_e1_data", 64'(data_out), 64'h00000205);
    chk("skew_e1_act_ready", 64'(act_ready), 64'd0);
    act_valid = 1'b0; act_last = 1'b0;
    step();  // E2
    chk("skew_e2_data", 64'(data_out), 64'h00030600);
    step();  // E3
    chk("skew_e3_data", 64'(data_out), 64'h04070000);
    chk("skew_e3_done", 64'(done), 64'd0);
    step();  // E4
    chk("skew_e4_lane3", 64'(data_out[31:24]), 64'd8);
    chk("skew_e4_vld", 64'(data_vld), 64'b1000);
    chk("skew_e4_done", 64'(done), 64'd1);
    chk("skew_e4_busy", 64'(busy), 64'd0);
    step();
    chk("skew_after_done", 64'(done), 64'd0);
    chk("skew_after_data", 64'(data_out), 64'd0);

    // ---- weight stall, then single-vector job ----
    do_start();
    wt_valid = 1'b1;
    wt_row = 32'h11111111; step();
    wt_row = 32'h22222222; step();
    chk("stall_row2", 64'(wt_path_out), 64'h22222222);
    wt_valid = 1'b0; wt_row = 32'hDEADBEEF;
    for (int g = 0; g < 2; g++) begin
      step();
      chk("stall_control", 64'(control), 64'd0);
      chk("stall_hold", 64'(wt_path_out), 64'h22222222);
      chk("stall_wt_ready", 64'(wt_ready), 64'd1);
    end
    wt_valid = 1'b1;
    wt_row = 32'h33333333; step();
    chk("stall_row3", 64'(control), 64'd1);
    wt_row = 32'h44444444; step();
    chk("stall_row4", 64'(wt_path_out), 64'h44444444);
    chk("stall_to_stream", 64'(act_ready), 64'd1);
    wt_valid = 1'b0;
    act_valid = 1'b1; act_vec = 32'h09090909; act_last = 1'b1;
    step();  // acceptance
    act_valid = 1'b0; act_last = 1'b0;
    chk("single_act_ready", 64'(act_ready), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);
    step();
    chk("single_done_early1", 64'(done), 64'd0);
    step();
    chk("single_done_early2", 64'(done), 64'd0);
    step();
    chk("single_done", 64'(done), 64'd1);
    chk("single_busy_fall", 64'(busy), 64'd0);
    chk("single_lane3", 64'(data_out[31:24]), 64'd9);
    step();

    // ---- bubble between two vectors ----
    do_start();
    load_rows();
    act_valid = 1'b1; act_vec = 32'hA4A3A2A1; step();  // E0
    act_valid = 1'b0; step();                          // E1 bubble
    chk("bubble_e1_vld", 64'(data_vld), 64'b0010);
    act_valid = 1'b1; act_vec = 32'hB4B3B2B1; act_last = 1'b1; step();  // E2
    act_valid = 1'b0; act_last = 1'b0;
    chk("bubble_e2_vld", 64'(data_vld), 64'b0101);
    chk("bubble_e2_lane1", 64'(data_out[15:8]), 64'd0);
    step();
    chk("bubble_e3_vld", 64'(data_vld), 64'b1010);
    step();
    chk("bubble_e4_vld", 64'(data_vld), 64'b0100);
    step();
    chk("bubble_e5_done", 64'(done), 64'd1);
    chk("bubble_e5_lane3", 64'(data_out[31:24]), 64'hB4);
    step();

    // ---- reset mid-STREAM ----
    do_start();
    load_rows();
    act_valid = 1'b1; act_vec = 32'h55667788; step();
    act_valid = 1'b0;
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom % 8) == 0;
      wt_valid  = ($urandom % 3) != 0;
      wt_row    = LW'($urandom);
      act_valid = ($urandom % 4) != 0;
      act_vec   = LW'($urandom);
      act_last  = ($urandom % 6) == 0;
      if (($urandom % 500) == 0) pulse_reset();
      else step();
    end
    start = 1'b0; wt_valid = 1'b0; act_valid = 1'b0; act_last = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
